// File: rtl/nes_pkg.sv
// nes_pkg: opcodes, types and loader state encoding shared by
// the NES host-side command port logic.
package nes_pkg;

  typedef logic [7:0] nes_op_t;

  localparam nes_op_t RESET_CPU = 8'h00;
  localparam nes_op_t START_CPU = 8'h01;
  localparam nes_op_t PAUSE_CPU = 8'h02;
  localparam nes_op_t WRITE_MEM = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LOAD,
    ST_STRT,
    ST_RUN,
    ST_PSE,
    ST_HALT
  } nes_loader_state_t;

endpackage

// File: rtl/nes_loader_if.sv
// nes_loader_if: Avalon-MM write bus between the loader (master)
// and the NES command port (slave).
interface nes_loader_if;

  logic        m_chipselect;
  logic        m_write;
  logic [15:0] m_address;
  logic [15:0] m_writedata;
  logic        m_waitrequest;

  modport master (
    output m_chipselect,
    output m_write,
    output m_address,
    output m_writedata,
    input  m_waitrequest
  );

  modport slave (
    input  m_chipselect,
    input  m_write,
    input  m_address,
    input  m_writedata,
    output m_waitrequest
  );

endinterface

// File: rtl/nes_av_wr_beat.sv
// nes_av_wr_beat: issues one Avalon write per request pulse and
// holds it until the slave drops waitrequest.
module nes_av_wr_beat
  import nes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  nes_op_t      op,
  input  logic [7:0]   payload,
  input  logic [15:0]  addr,
  output logic         beat_done,
  nes_loader_if.master av
);

  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  assign beat_done = write_q & ~av.m_waitrequest;

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (beat_done) begin
      write_d = 1'b0;
    end else if (req && !write_q) begin
      write_d = 1'b1;
      addr_d  = addr;
      data_d  = {op, payload};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign av.m_write      = write_q;
  assign av.m_chipselect = write_q;
  assign av.m_address    = addr_q;
  assign av.m_writedata  = data_q;

endmodule

// File: rtl/nes_loader.sv
// nes_loader: resets the NES CPU, streams an image into memory, starts it.
// Optional NES_LOADER_CHECKSUM_EN adds an 8-bit payload checksum output.
module nes_loader
  import nes_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              pause_req,
  input  logic              resume_req,
  nes_loader_if.master      av,
  output logic              busy,
  output logic              running,
  output logic              done
`ifdef NES_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  nes_loader_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              kick_q, kick_d;
  logic              s_ready_q, s_ready_d;
  logic              seq_q, seq_d;
  logic              busy_q, busy_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic        accept;
  logic        req;
  nes_op_t     op;
  logic [7:0]  payload;
  logic [15:0] beat_addr;
  logic        beat_done;

  assign accept = go & (state_q inside {ST_IDLE, ST_RUN, ST_HALT});

  // kick_q fires the single beat of RST/STRT/PSE in their first cycle
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    kick_d    = 1'b0;
    s_ready_d = s_ready_q;
    seq_d     = seq_q;
    done_d    = 1'b0;
    req       = kick_q;
    op        = RESET_CPU;
    payload   = 8'h00;
    beat_addr = 16'h0000;
    case (state_q)
      ST_RST: begin
        if (beat_done) begin
          if (cnt_q != '0) begin
            state_d   = ST_LOAD;
            s_ready_d = 1'b1;
          end else begin
            state_d = ST_STRT;
            kick_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        op        = WRITE_MEM;
        payload   = s_data;
        beat_addr = 16'(addr_q);
        if (s_valid && s_ready_q) begin
          req       = 1'b1;
          s_ready_d = 1'b0;
        end
        if (beat_done) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) begin
            state_d = ST_STRT;
            kick_d  = 1'b1;
          end else begin
            s_ready_d = 1'b1;
          end
        end
      end
      ST_STRT: begin
        op = START_CPU;
        if (beat_done) begin
          state_d = ST_RUN;
          done_d  = seq_q;
          seq_d   = 1'b0;
        end
      end
      ST_PSE: begin
        op = PAUSE_CPU;
        if (beat_done) state_d = ST_HALT;
      end
      ST_RUN: begin
        if (pause_req) begin
          state_d = ST_PSE;
          kick_d  = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume_req) begin
          state_d = ST_STRT;
          kick_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d   = ST_RST;
      addr_d    = base_addr;
      cnt_d     = length;
      kick_d    = 1'b1;
      seq_d     = 1'b1;
      s_ready_d = 1'b0;
    end
    busy_d    = state_d inside {ST_RST, ST_LOAD, ST_STRT, ST_PSE};
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      kick_q    <= 1'b0;
      s_ready_q <= 1'b0;
      seq_q     <= 1'b0;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      kick_q    <= kick_d;
      s_ready_q <= s_ready_d;
      seq_q     <= seq_d;
      busy_q    <= busy_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  nes_av_wr_beat u_beat (
    .clk       (clk),
    .rst       (reset),
    .req       (req),
    .op        (op),
    .payload   (payload),
    .addr      (beat_addr),
    .beat_done (beat_done),
    .av        (av)
  );

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign running = running_q;
  assign done    = done_q;

`ifdef NES_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = 8'h00;
    end else if (state_q == ST_LOAD && beat_done) begin
      sum_d = sum_q + av.m_writedata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_nes_loader.sv
// tb_nes_loader: randomized bench checking nes_loader beats against
// an expected beat list built from the command-sequence rules.
`timescale 1ns/1ps
module tb_nes_loader;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        s_valid = 1'b0;
  logic        pause_req = 1'b0;
  logic        resume_req = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic [15:0] length = 16'h0000;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, busy, running, done;
`ifdef NES_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  nes_loader_if bus();

  nes_loader #(.ADDR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .base_addr  (base_addr),
    .length     (length),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pause_req  (pause_req),
    .resume_req (resume_req),
    .av         (bus),
    .busy       (busy),
    .running    (running),
    .done       (done)
`ifdef NES_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // wmode: 0 no stall, 1 four stalls per beat, 2 random,
  // 4 stall WRITE_MEM beats forever
  int          wmode = 0;
  int          svrand = 0;
  int          hold = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          sr_cnt = 0;
  logic        stall_p = 1'b0;
  logic [15:0] pa, pd;
  logic [7:0]  src_q[$];
  logic [7:0]  img_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int          stamp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stall_p = 1'b0;
      hold = 0;
      s_valid = 1'b0;
      bus.m_waitrequest = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stable_w", bus.m_write, 1);
        chk("stable_a", bus.m_address, pa);
        chk("stable_d", bus.m_writedata, pd);
      end
      chk("cs_eq_write", bus.m_chipselect, bus.m_write);
      case (wmode)
        1: bus.m_waitrequest = bus.m_write && hold < 4;
        2: bus.m_waitrequest = ($urandom_range(0, 2) == 0);
        4: bus.m_waitrequest = (bus.m_writedata[15:8] == WRITE_MEM);
        default: bus.m_waitrequest = 1'b0;
      endcase
      if (bus.m_write && bus.m_waitrequest) hold++;
      else hold = 0;
      stall_p = bus.m_write && bus.m_waitrequest;
      pa = bus.m_address;
      pd = bus.m_writedata;
      if (bus.m_write && !bus.m_waitrequest) begin
        obs_q.push_back({bus.m_address, bus.m_writedata});
        stamp_q.push_back(cyc);
      end
      if (done) done_cnt++;
      if (s_ready) sr_cnt++;
      s_valid = src_q.size() > 0 &&
                (svrand == 0 || $urandom_range(0, 1) == 1);
      s_data = s_valid ? src_q[0] : 8'h00;
      if (s_valid && s_ready) void'(src_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp_beats(input string tag);
    chk($sformatf("%s_nbeats", tag), obs_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < obs_q.size()) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    stamp_q.delete();
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin
      tick(1);
      k++;
    end
    chk("done_timeout", done_cnt != d0, 1);
  endtask

  task automatic run_go(input logic [15:0] base, input string tag,
                        input bit gap);
    int d0, sr0, n;
    n = img_q.size();
    d0 = done_cnt;
    sr0 = sr_cnt;
    exp_q.push_back({16'h0000, RESET_CPU, 8'h00});
    foreach (img_q[i]) begin
      exp_q.push_back({base + 16'(i), WRITE_MEM, img_q[i]});
      src_q.push_back(img_q[i]);
    end
    exp_q.push_back({16'h0000, START_CPU, 8'h00});
    base_addr = base;
    length = 16'(n);
    go = 1'b1;
    tick(1);
    go = 1'b0;
    chk("go_lat0", bus.m_write, 0);
    tick(1);
    chk("go_lat1", bus.m_write, 1);
    wait_done(d0);
    tick(3);
    if (gap && stamp_q.size() >= 4) begin
      chk("gap1", stamp_q[2] - stamp_q[1], 2);
      chk("gap2", stamp_q[3] - stamp_q[2], 2);
    end
    cmp_beats(tag);
    chk("done_once", done_cnt - d0, 1);
    chk("running", running, 1);
    chk("busy", busy, 0);
    chk("src_left", src_q.size(), 0);
    if (n == 0) chk("s_ready_len0", sr_cnt - sr0, 0);
`ifdef NES_LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = 8'h00;
      foreach (img_q[i]) sum += img_q[i];
      chk("checksum", checksum, sum);
    end
`endif
  endtask

  task automatic run_pause();
    int d0, k;
    d0 = done_cnt;
    resume_req = 1'b1;
    tick(1);
    resume_req = 1'b0;
    tick(4);
    cmp_beats("resume_ignored");
    exp_q.push_back({16'h0000, PAUSE_CPU, 8'h00});
    pause_req = 1'b1;
    tick(1);
    pause_req = 1'b0;
    k = 0;
    while (busy && k < 3000) begin
      tick(1);
      k++;
    end
    chk("pause_timeout", busy, 0);
    tick(3);
    cmp_beats("pause");
    chk("pause_running", running, 0);
    exp_q.push_back({16'h0000, START_CPU, 8'h00});
    resume_req = 1'b1;
    tick(1);
    resume_req = 1'b0;
    k = 0;
    while (!running && k < 3000) begin
      tick(1);
      k++;
    end
    chk("resume_timeout", running, 1);
    tick(3);
    cmp_beats("resume");
    chk("resume_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    #2 reset = 1'b1;
    tick(2);
    chk("rst_write", bus.m_write, 0);
    chk("rst_cs", bus.m_chipselect, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", bus.m_address, 16'h0000);
    chk("rst_data", bus.m_writedata, 16'h0000);
    reset = 1'b0;
    tick(2);

    img_q.delete();
    img_q.push_back(8'hA9);
    img_q.push_back(8'h01);
    img_q.push_back(8'hEA);
    run_go(16'h8000, "basic", 1'b1);

    wmode = 1;
    run_go(16'h8000, "stall4", 1'b0);

    wmode = 0;
    img_q.delete();
    img_q.push_back(8'h5A);
    img_q.push_back(8'hC3);
    run_go(16'hFFFF, "wrap", 1'b0);

    img_q.delete();
    run_go(16'h4000, "len0", 1'b0);

    run_pause();

    wmode = 4;
    img_q.delete();
    img_q.push_back(8'hFF);
    img_q.push_back(8'h02);
    foreach (img_q[i]) src_q.push_back(img_q[i]);
    base_addr = 16'h0100;
    length = 16'd2;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    begin
      int k = 0;
      while (!(bus.m_write && bus.m_writedata[15:8] == WRITE_MEM) &&
             k < 3000) begin
        tick(1);
        k++;
      end
    end
    chk("stalled_wr", bus.m_write, 1);
    tick(2);
    reset = 1'b1;
    #1;
    chk("abort_write", bus.m_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_running", running, 0);
    src_q.delete();
    obs_q.delete();
    exp_q.delete();
    stamp_q.delete();
    tick(1);
    reset = 1'b0;
    wmode = 0;
    tick(1);
    run_go(16'h0100, "after_abort", 1'b0);

    svrand = 1;
    for (int it = 0; it < 12; it++) begin
      int n;
      wmode = int'($urandom_range(0, 2));
      n = int'($urandom_range(0, 10));
      img_q.delete();
      for (int j = 0; j < n; j++) img_q.push_back(8'($urandom));
      run_go(16'($urandom), "rand", 1'b0);
      if ($urandom_range(0, 2) == 0) run_pause();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
